// File: rtl/traffic_pkg.sv
// Shared phase encoding, sequence landmarks and q-to-phase decode for traffic_seq.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_AG = 2'd0,
    PH_AY = 2'd1,
    PH_BG = 2'd2,
    PH_BY = 2'd3
  } phase_e;

  localparam logic [5:0] Q_AY   = 6'd20;
  localparam logic [5:0] Q_BG   = 6'd24;
  localparam logic [5:0] Q_BY   = 6'd44;
  localparam logic [5:0] Q_LAST = 6'd47;

  function automatic phase_e phase_of(input logic [5:0] qv);
    if (qv < Q_AY)      return PH_AG;
    else if (qv < Q_BG) return PH_AY;
    else if (qv < Q_BY) return PH_BG;
    else                return PH_BY;
  endfunction

endpackage

// File: rtl/traffic_seq_tick_gen.sv
// Prescaler: counts CLK_DIV cycles while enabled and pulses adv_tick on the last one.
module tick_gen #(
  parameter int unsigned CLK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic adv_tick
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Pausing clears the count so a resume always waits a full period.
  always_comb begin
    adv_tick = en && (cnt_q == CNT_LAST);
    cnt_d    = '0;
    if (en && !adv_tick) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/traffic_seq.sv
// Traffic-light sequencer: 48-state q counter with phase decode, pause and manual step.
// Optional side-B demand hold at q = 19 is enabled by defining TRAFFIC_SENSOR_EN.
module traffic_seq
  import traffic_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       step,
`ifdef TRAFFIC_SENSOR_EN
  input  logic       b_req,
`endif
  output logic [5:0] q,
  output logic [1:0] phase,
  output logic       tick
);

  logic       adv_tick;
  logic       adv;
  logic [5:0] q_q, q_d;
  phase_e     phase_q, phase_d;
  logic       tick_q, tick_d;

  tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .adv_tick (adv_tick)
  );

  // Phase is decoded from the next q so both registers change on the same edge.
  always_comb begin
    adv    = en ? adv_tick : step;
    q_d    = q_q;
    tick_d = adv;
    if (adv) begin
      if (q_q >= Q_LAST) q_d = '0;
`ifdef TRAFFIC_SENSOR_EN
      else if ((q_q == Q_AY - 6'd1) && !b_req) q_d = q_q;
`endif
      else q_d = q_q + 6'd1;
    end
    phase_d = phase_of(q_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q     <= '0;
      phase_q <= PH_AG;
      tick_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      phase_q <= phase_d;
      tick_q  <= tick_d;
    end
  end

  assign q     = q_q;
  assign phase = phase_q;
  assign tick  = tick_q;

endmodule

// File: tb/tb_traffic_seq.sv
// Self-checking bench for traffic_seq (CLK_DIV = 4) against a cycle-level behavioural model.
module tb_traffic_seq;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       step = 1'b0;
`ifdef TRAFFIC_SENSOR_EN
  logic       b_req = 1'b1;
`endif
  logic [5:0] q;
  logic [1:0] phase;
  logic       tick;

  int checks = 0;
  int errors = 0;

  // Model state: light position 0..47, cycles spent running since last tick/resume, tick flag.
  int m_q = 0;
  int m_run = 0;
  bit m_tick = 1'b0;

  always #5 clk = ~clk;

  traffic_seq #(.CLK_DIV(CLK_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .step  (step),
`ifdef TRAFFIC_SENSOR_EN
    .b_req (b_req),
`endif
    .q     (q),
    .phase (phase),
    .tick  (tick)
  );

  function automatic logic [1:0] exp_phase(input int v);
    if (v < 20)      return 2'd0;
    else if (v < 24) return 2'd1;
    else if (v < 44) return 2'd2;
    else             return 2'd3;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q = 0; m_run = 0; m_tick = 1'b0;
    end else begin
      bit a;
      bit hold;
      a = en ? (m_run == CLK_DIV - 1) : step;
      m_run = en ? (m_run + 1) % CLK_DIV : 0;
      m_tick = a;
      hold = 1'b0;
`ifdef TRAFFIC_SENSOR_EN
      hold = (m_q == 19) && !b_req;
`endif
      if (a && !hold) m_q = (m_q + 1) % 48;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached (q=%0d)", q);
    $fatal(1, "watchdog");
  end

  task automatic run_to(input int target);
    int n = 0;
    en = 1'b1;
    while (!(m_q == target && m_tick) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL run_to: q=%0d never reached %0d", q, target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; step = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (q !== 6'd0)   begin errors++; $display("FAIL reset_q: got %0d want 0", q); end
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL reset_phase: got %0d want 0", phase); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %0b want 0", tick); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (q !== 6'd0) begin errors++; $display("FAIL reset_idle_q: got %0d want 0", q); end
  endtask

  task automatic test_full_cycle();
    int nt = 0;
    int chg[$];
    int expc[4] = '{20, 24, 44, 0};
    logic [1:0] prev;
    prev = phase;
    en = 1'b1;
    repeat (4 * 48) begin
      @(negedge clk);
      checks++; if (q !== 6'(m_q)) begin errors++; $display("FAIL cycle_q: got %0d want %0d", q, m_q); end
      checks++; if (phase !== exp_phase(m_q)) begin errors++; $display("FAIL cycle_phase: got %0d want %0d", phase, exp_phase(m_q)); end
      checks++; if (tick !== m_tick) begin errors++; $display("FAIL cycle_tick: got %0b want %0b", tick, m_tick); end
      if (tick) nt++;
      if (phase !== prev) begin chg.push_back(int'(q)); prev = phase; end
    end
    checks++; if (nt != 48) begin errors++; $display("FAIL cycle_tick_count: got %0d want 48", nt); end
    checks++; if (q !== 6'd0) begin errors++; $display("FAIL cycle_wrap: got %0d want 0", q); end
    checks++;
    if (chg.size() != 4) begin
      errors++; $display("FAIL cycle_phase_changes: got %0d changes want 4", chg.size());
    end else begin
      foreach (expc[i]) begin
        checks++;
        if (chg[i] != expc[i]) begin errors++; $display("FAIL cycle_phase_at: got q=%0d want q=%0d", chg[i], expc[i]); end
      end
    end
  endtask

  task automatic test_pause();
    int k;
    run_to(5);
    en = 1'b0;
    repeat (20) begin
      @(negedge clk);
      checks++; if (q !== 6'd5 || tick !== 1'b0) begin errors++; $display("FAIL pause_hold: got q=%0d tick=%0b want q=5 tick=0", q, tick); end
    end
    en = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!tick && k < 20);
    checks++; if (k != 4) begin errors++; $display("FAIL pause_resume_latency: got %0d want 4", k); end
    checks++; if (q !== 6'd6) begin errors++; $display("FAIL pause_resume_q: got %0d want 6", q); end
    repeat (4) begin
      en = 1'b1;
      repeat ($urandom_range(1, 12)) begin
        @(negedge clk);
        checks++; if (q !== 6'(m_q) || tick !== m_tick) begin errors++; $display("FAIL pause_rand_run: got q=%0d tick=%0b want q=%0d tick=%0b", q, tick, m_q, m_tick); end
      end
      en = 1'b0;
      repeat ($urandom_range(1, 10)) begin
        @(negedge clk);
        checks++; if (q !== 6'(m_q) || tick !== 1'b0) begin errors++; $display("FAIL pause_rand_hold: got q=%0d tick=%0b want q=%0d tick=0", q, tick, m_q); end
      end
    end
  endtask

  task automatic test_step();
    run_to(23);
    en = 1'b0;
    repeat ($urandom_range(1, 5)) @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    checks++; if (q !== 6'd24) begin errors++; $display("FAIL step_q: got %0d want 24", q); end
    checks++; if (phase !== 2'd2) begin errors++; $display("FAIL step_phase: got %0d want 2", phase); end
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL step_tick: got %0b want 1", tick); end
    @(negedge clk);
    checks++; if (tick !== 1'b0 || q !== 6'd24) begin errors++; $display("FAIL step_tick_width: got q=%0d tick=%0b want q=24 tick=0", q, tick); end
    step = 1'b1;
    repeat (2) @(negedge clk);
    step = 1'b0;
    checks++; if (q !== 6'd26) begin errors++; $display("FAIL step_b2b: got %0d want 26", q); end
    repeat (30) begin
      step = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++; if (q !== 6'(m_q) || tick !== m_tick) begin errors++; $display("FAIL step_rand: got q=%0d tick=%0b want q=%0d tick=%0b", q, tick, m_q, m_tick); end
    end
    step = 1'b0;
  endtask

  task automatic test_step_while_running();
    int last = 0;
    int cyc = 0;
    en = 1'b1;
    repeat (48) begin
      step = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
      checks++; if (q !== 6'(m_q) || tick !== m_tick) begin errors++; $display("FAIL run_step_model: got q=%0d tick=%0b want q=%0d tick=%0b", q, tick, m_q, m_tick); end
      if (tick) begin
        checks++; if (cyc - last != 4) begin errors++; $display("FAIL run_step_period: got %0d want 4", cyc - last); end
        last = cyc;
      end
    end
    step = 1'b0;
  endtask

  task automatic test_async_reset();
    int k;
    run_to(30);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (q !== 6'd0) begin errors++; $display("FAIL areset_q: got %0d want 0", q); end
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL areset_phase: got %0d want 0", phase); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL areset_tick: got %0b want 0", tick); end
    @(negedge clk);
    rst_n = 1'b1;
    run_to(3);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (q !== 6'd0) begin errors++; $display("FAIL areset_mid_q: got %0d want 0", q); end
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!tick && k < 20);
    checks++; if (k != 4) begin errors++; $display("FAIL areset_prescale: got %0d want 4", k); end
    checks++; if (q !== 6'd1) begin errors++; $display("FAIL areset_first_q: got %0d want 1", q); end
  endtask

`ifdef TRAFFIC_SENSOR_EN
  task automatic test_sensor();
    int nt = 0;
    int k;
    b_req = 1'b1;
    run_to(19);
    b_req = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (tick) nt++;
      checks++; if (q !== 6'd19) begin errors++; $display("FAIL sensor_hold_q: got %0d want 19", q); end
    end
    checks++; if (nt != 3) begin errors++; $display("FAIL sensor_hold_ticks: got %0d want 3", nt); end
    b_req = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!tick && k < 8);
    checks++; if (q !== 6'd20 || phase !== 2'd1) begin errors++; $display("FAIL sensor_release: got q=%0d phase=%0d want q=20 phase=1", q, phase); end
    run_to(19);
    en = 1'b0;
    b_req = 1'b0;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    checks++; if (q !== 6'd19 || tick !== 1'b1) begin errors++; $display("FAIL sensor_step_hold: got q=%0d tick=%0b want q=19 tick=1", q, tick); end
    b_req = 1'b1;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    checks++; if (q !== 6'd20 || phase !== 2'd1) begin errors++; $display("FAIL sensor_step_release: got q=%0d phase=%0d want q=20 phase=1", q, phase); end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_full_cycle();
    test_pause();
    test_step();
    test_step_while_running();
    test_async_reset();
`ifdef TRAFFIC_SENSOR_EN
    test_sensor();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
